// File: rtl/pwm_fade_controller.sv
// Duty-cycle fader: walks pwm_duty_cycle toward a latched target in saturating
// steps at a programmable rate. Optional breathe mode compiled in by PWM_FADE_BREATHE_EN.
module pwm_fade_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] target_duty,
  input  logic [3:0] step_size,
  input  logic [7:0] prescale,
  input  logic       breathe,
  output logic [7:0] pwm_duty_cycle,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] duty_reg, duty_next;
  logic [7:0] target_reg, target_next;
  logic [3:0] step_reg, step_next;
  logic [7:0] prescale_reg, prescale_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       done_reg, done_next;
  // Set while a breathe cycle is heading down to 0x00 instead of the target.
  logic       floor_reg, floor_next;

  logic breathe_on;
`ifdef PWM_FADE_BREATHE_EN
  assign breathe_on = breathe;
`else
  logic unused_breathe;
  assign unused_breathe = breathe;
  assign breathe_on     = 1'b0;
`endif

  logic [8:0] step9;
  logic [7:0] goal;
  logic [8:0] up_sum;
  logic [8:0] down_diff;
  logic [7:0] up_val;
  logic [7:0] down_val;
  logic [7:0] stepped;
  logic       tick;
  state_t     launch_state;
  logic       launch_done;

  // Saturating 9-bit step toward the current goal; never passes it, never wraps.
  always_comb begin
    step9     = {5'd0, (step_reg == 4'd0) ? 4'd1 : step_reg};
    goal      = floor_reg ? 8'h00 : target_reg;
    up_sum    = {1'b0, duty_reg} + step9;
    down_diff = {1'b0, duty_reg} - step9;
    up_val    = (up_sum >= {1'b0, goal}) ? goal : up_sum[7:0];
    down_val  = (down_diff[8] || (down_diff[7:0] <= goal)) ? goal : down_diff[7:0];
    stepped   = (state_reg == RAMP_UP) ? up_val : down_val;
    tick      = (cnt_reg >= prescale_reg);
  end

  always_comb begin
    launch_state = HOLD;
    launch_done  = 1'b0;
    if (target_duty > duty_reg) begin
      launch_state = RAMP_UP;
    end else if (target_duty < duty_reg) begin
      launch_state = RAMP_DOWN;
    end else begin
      launch_done = 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    duty_next     = duty_reg;
    target_next   = target_reg;
    step_next     = step_reg;
    prescale_next = prescale_reg;
    cnt_next      = cnt_reg;
    floor_next    = floor_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE, HOLD: begin
        if (start && !abort) begin
          target_next   = target_duty;
          step_next     = step_size;
          prescale_next = prescale;
          cnt_next      = 8'd0;
          floor_next    = 1'b0;
          state_next    = launch_state;
          done_next     = launch_done;
        end
      end

      RAMP_UP, RAMP_DOWN: begin
        if (abort) begin
          state_next = HOLD;
          floor_next = 1'b0;
        end else if (start) begin
          // Retarget keeps the step phase running; only parameters and direction change.
          target_next   = target_duty;
          step_next     = step_size;
          prescale_next = prescale;
          cnt_next      = cnt_reg + 8'd1;
          floor_next    = 1'b0;
          state_next    = launch_state;
          done_next     = launch_done;
        end else if (tick) begin
          cnt_next  = 8'd0;
          duty_next = stepped;
          if (stepped == goal) begin
            if (floor_reg) begin
              state_next = RAMP_UP;
              floor_next = 1'b0;
            end else begin
              done_next = 1'b1;
              if (breathe_on && (target_reg != 8'h00)) begin
                state_next = RAMP_DOWN;
                floor_next = 1'b1;
              end else begin
                state_next = HOLD;
              end
            end
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      duty_reg     <= 8'h00;
      target_reg   <= 8'h00;
      step_reg     <= 4'd0;
      prescale_reg <= 8'h00;
      cnt_reg      <= 8'h00;
      done_reg     <= 1'b0;
      floor_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      duty_reg     <= duty_next;
      target_reg   <= target_next;
      step_reg     <= step_next;
      prescale_reg <= prescale_next;
      cnt_reg      <= cnt_next;
      done_reg     <= done_next;
      floor_reg    <= floor_next;
    end
  end

  assign pwm_duty_cycle = duty_reg;
  assign done           = done_reg;
  assign busy           = (state_reg == RAMP_UP) || (state_reg == RAMP_DOWN);

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Self-checking bench for pwm_fade_controller: directed scenarios plus randomized
// fades compared against a step-countdown reference model.
module tb_pwm_fade_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] target_duty;
  logic [3:0] step_size;
  logic [7:0] prescale;
  logic       breathe;
  logic [7:0] pwm_duty_cycle;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: duty, goal, step, rate, cycles left until next step.
  int m_duty, m_goal, m_step, m_pre, m_wait;
  bit m_ramp, m_done;

  always #5 clk = ~clk;

  pwm_fade_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .target_duty    (target_duty),
    .step_size      (step_size),
    .prescale       (prescale),
    .breathe        (breathe),
    .pwm_duty_cycle (pwm_duty_cycle),
    .busy           (busy),
    .done           (done)
  );

  function automatic void model_reset();
    m_duty = 0; m_goal = 0; m_step = 1; m_pre = 0; m_wait = 0;
    m_ramp = 0; m_done = 0;
  endfunction

  function automatic void model_step(bit st, bit ab, int tg, int ss, int ps);
    m_done = 0;
    if (m_ramp) begin
      if (ab) begin
        m_ramp = 0;
      end else if (m_wait == 0) begin
        if (m_goal > m_duty) m_duty = (m_duty + m_step > m_goal) ? m_goal : m_duty + m_step;
        else                 m_duty = (m_duty - m_step < m_goal) ? m_goal : m_duty - m_step;
        m_wait = m_pre;
        if (m_duty == m_goal) begin
          m_ramp = 0;
          m_done = 1;
        end
      end else begin
        m_wait--;
      end
    end else if (st && !ab) begin
      m_goal = tg;
      m_step = (ss == 0) ? 1 : ss;
      m_pre  = ps;
      m_wait = ps;
      if (tg == m_duty) m_done = 1;
      else              m_ramp = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    tick();
    model_step(start, abort, int'(target_duty), int'(step_size), int'(prescale));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_params(input int tg, input int ss, input int ps);
    target_duty = 8'(tg);
    step_size   = 4'(ss);
    prescale    = 8'(ps);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (pwm_duty_cycle !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: duty=%02h busy=%b done=%b, required duty=00 busy=0 done=0",
               pwm_duty_cycle, busy, done);
    end
  endtask

  task automatic test_ramp_fast();
    int changes[$];
    int exp_seq[4] = '{8'h04, 8'h08, 8'h0C, 8'h10};
    int n_done = 0;
    int prev;
    do_reset();
    set_params(8'h10, 4, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cycle();
      n_checks++;
      if (pwm_duty_cycle !== 8'(m_duty) || busy !== m_ramp || done !== m_done) begin
        n_fail++;
        $display("FAIL ramp_fast cyc=%0d: duty=%02h busy=%b done=%b, required %02h %b %b",
                 i, pwm_duty_cycle, busy, done, m_duty[7:0], m_ramp, m_done);
      end
      if (int'(pwm_duty_cycle) != prev) changes.push_back(int'(pwm_duty_cycle));
      prev = int'(pwm_duty_cycle);
      if (done === 1'b1) begin
        n_done++;
        n_checks++;
        if (pwm_duty_cycle !== 8'h10) begin
          n_fail++;
          $display("FAIL ramp_fast_done_value: duty=%02h, required 10", pwm_duty_cycle);
        end
      end
    end
    n_checks++;
    if (changes.size() != 4 || changes[0] != exp_seq[0] || changes[1] != exp_seq[1] ||
        changes[2] != exp_seq[2] || changes[3] != exp_seq[3]) begin
      n_fail++;
      $display("FAIL ramp_fast_sequence: %0d changes %p, required 04 08 0C 10", changes.size(), changes);
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL ramp_fast_done_count: %0d, required 1", n_done);
    end
    $display("txn ramp_fast: target=10 step=4 prescale=0 -> duty=%02h", pwm_duty_cycle);
  endtask

  task automatic test_ramp_slow();
    int chg_cyc[$];
    int chg_val[$];
    int prev = 0;
    bit saw_0c = 0;
    do_reset();
    set_params(8'h0A, 4, 3);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      n_checks++;
      if (pwm_duty_cycle !== 8'(m_duty) || busy !== m_ramp || done !== m_done) begin
        n_fail++;
        $display("FAIL ramp_slow cyc=%0d: duty=%02h busy=%b done=%b, required %02h %b %b",
                 i, pwm_duty_cycle, busy, done, m_duty[7:0], m_ramp, m_done);
      end
      if (pwm_duty_cycle == 8'h0C) saw_0c = 1;
      if (int'(pwm_duty_cycle) != prev) begin
        chg_cyc.push_back(i);
        chg_val.push_back(int'(pwm_duty_cycle));
      end
      prev = int'(pwm_duty_cycle);
    end
    n_checks++;
    if (chg_cyc.size() != 3 || chg_cyc[0] != 4 || chg_cyc[1] != 8 || chg_cyc[2] != 12 ||
        chg_val[0] != 4 || chg_val[1] != 8 || chg_val[2] != 10) begin
      n_fail++;
      $display("FAIL ramp_slow_timing: cycles %p values %p, required cycles 4 8 12 values 4 8 10",
               chg_cyc, chg_val);
    end
    n_checks++;
    if (saw_0c) begin
      n_fail++;
      $display("FAIL ramp_slow_overshoot: duty reached 0C, required never");
    end
    $display("txn ramp_slow: target=0A step=4 prescale=3 -> duty=%02h", pwm_duty_cycle);
  endtask

  task automatic test_full_scale();
    int n_chg = 0;
    int n_done = 0;
    bit wrapped = 0;
    int prev;
    do_reset();
    set_params(8'hFF, 15, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    n_checks++;
    if (pwm_duty_cycle !== 8'hFF || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_scale_up: duty=%02h busy=%b, required FF 0", pwm_duty_cycle, busy);
    end
    set_params(8'h00, 15, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    prev = int'(pwm_duty_cycle);
    for (int i = 0; i < 22; i++) begin
      cycle();
      n_checks++;
      if (pwm_duty_cycle !== 8'(m_duty) || busy !== m_ramp || done !== m_done) begin
        n_fail++;
        $display("FAIL full_scale_down cyc=%0d: duty=%02h busy=%b done=%b, required %02h %b %b",
                 i, pwm_duty_cycle, busy, done, m_duty[7:0], m_ramp, m_done);
      end
      if (int'(pwm_duty_cycle) > prev) wrapped = 1;
      if (int'(pwm_duty_cycle) != prev) n_chg++;
      if (done === 1'b1) n_done++;
      prev = int'(pwm_duty_cycle);
    end
    n_checks++;
    if (n_chg != 17 || n_done != 1 || wrapped || pwm_duty_cycle !== 8'h00) begin
      n_fail++;
      $display("FAIL full_scale_summary: steps=%0d dones=%0d wrap=%b duty=%02h, required 17 1 0 00",
               n_chg, n_done, wrapped, pwm_duty_cycle);
    end
    $display("txn full_scale: FF->00 step=15 prescale=0 -> duty=%02h", pwm_duty_cycle);
  endtask

  task automatic test_abort();
    int guard = 0;
    do_reset();
    set_params(8'h20, 4, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    while (pwm_duty_cycle != 8'h08 && guard < 20) begin
      cycle();
      guard++;
    end
    n_checks++;
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL abort_reach_08: duty=%02h, required 08 within 20 cycles", pwm_duty_cycle);
    end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    // Start together with abort while holding must be ignored.
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        set_params(8'h40, 2, 0);
        start = 1'b1;
        abort = 1'b1;
      end
      cycle();
      start = 1'b0;
      abort = 1'b0;
      n_checks++;
      if (pwm_duty_cycle !== 8'h08 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_hold cyc=%0d: duty=%02h busy=%b done=%b, required 08 0 0",
                 i, pwm_duty_cycle, busy, done);
      end
    end
    // Start together with abort during a ramp: abort freezes, new target ignored.
    set_params(8'h30, 1, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    set_params(8'h00, 1, 0);
    start = 1'b1;
    abort = 1'b1;
    cycle();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      n_checks++;
      if (pwm_duty_cycle !== 8'(m_duty) || busy !== m_ramp || done !== m_done ||
          pwm_duty_cycle !== 8'h0B) begin
        n_fail++;
        $display("FAIL abort_ramp cyc=%0d: duty=%02h busy=%b done=%b, required 0B 0 0",
                 i, pwm_duty_cycle, busy, done);
      end
    end
    $display("txn abort: frozen duty=%02h", pwm_duty_cycle);
  endtask

  task automatic test_mid_reset();
    int n_done = 0;
    do_reset();
    set_params(8'h80, 1, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (pwm_duty_cycle !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset cyc=%0d: duty=%02h busy=%b done=%b, required 00 0 0",
                 i, pwm_duty_cycle, busy, done);
      end
    end
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1 || pwm_duty_cycle !== 8'h00) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL mid_reset_after: %0d cycles with done or nonzero duty, required 0", n_done);
    end
    $display("txn mid_reset: duty=%02h", pwm_duty_cycle);
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    int n_done = 0;
    int rises = 0;
    int prev;
    do_reset();
    set_params(8'hC0, 2, 1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    // Retarget mid-ramp: direction flips to down, exact phase left unconstrained.
    set_params(8'h10, 3, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    prev = int'(pwm_duty_cycle);
    while ((busy === 1'b1) && guard < 200) begin
      tick();
      guard++;
      if (int'(pwm_duty_cycle) > prev) rises++;
      if (done === 1'b1) n_done++;
      prev = int'(pwm_duty_cycle);
    end
    tick();
    if (done === 1'b1) n_done++;
    n_checks++;
    if (guard >= 200 || rises != 0 || n_done != 1 || pwm_duty_cycle !== 8'h10) begin
      n_fail++;
      $display("FAIL retarget: cycles=%0d rises=%0d dones=%0d duty=%02h, required <200 0 1 10",
               guard, rises, n_done, pwm_duty_cycle);
    end
    model_reset();
    m_duty = 16;
    // Equal target pulses done immediately, then a new fade starts on the very next cycle.
    set_params(8'h10, 5, 2);
    start = 1'b1;
    cycle();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pwm_duty_cycle !== 8'h10) begin
      n_fail++;
      $display("FAIL equal_target: done=%b busy=%b duty=%02h, required 1 0 10", done, busy, pwm_duty_cycle);
    end
    set_params(8'h20, 0, 0);
    cycle();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_checks++;
      if (pwm_duty_cycle !== 8'(m_duty) || busy !== m_ramp || done !== m_done) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d: duty=%02h busy=%b done=%b, required %02h %b %b",
                 i, pwm_duty_cycle, busy, done, m_duty[7:0], m_ramp, m_done);
      end
    end
    $display("txn back_to_back: duty=%02h", pwm_duty_cycle);
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 30; t++) begin
      int guard = 0;
      bit mism = 0;
      set_params(int'($urandom_range(255)), int'($urandom_range(15)), int'($urandom_range(3)));
      start = 1'b1;
      cycle();
      start = 1'b0;
      n_checks++;
      if (pwm_duty_cycle !== 8'(m_duty) || busy !== m_ramp || done !== m_done) begin
        n_fail++;
        $display("FAIL random_launch txn=%0d: duty=%02h busy=%b done=%b, required %02h %b %b",
                 t, pwm_duty_cycle, busy, done, m_duty[7:0], m_ramp, m_done);
      end
      while (m_ramp && guard < 1200) begin
        abort = ($urandom_range(63) == 0);
        cycle();
        abort = 1'b0;
        guard++;
        n_checks++;
        if (pwm_duty_cycle !== 8'(m_duty) || busy !== m_ramp || done !== m_done) begin
          n_fail++;
          if (!mism)
            $display("FAIL random txn=%0d cyc=%0d: duty=%02h busy=%b done=%b, required %02h %b %b",
                     t, guard, pwm_duty_cycle, busy, done, m_duty[7:0], m_ramp, m_done);
          mism = 1;
        end
      end
      n_checks++;
      if (guard >= 1200) begin
        n_fail++;
        $display("FAIL random_timeout txn=%0d: still ramping after 1200 cycles", t);
      end
      $display("txn %0d: target=%02h step=%0d prescale=%0d -> duty=%02h",
               t, target_duty, step_size, prescale, pwm_duty_cycle);
    end
  endtask

`ifdef PWM_FADE_BREATHE_EN
  task automatic test_breathe();
    int exp_seq[10] = '{4, 8, 4, 0, 4, 8, 4, 0, 4, 8};
    int exp_tail[4] = '{4, 0, 4, 8};
    do_reset();
    breathe = 1'b1;
    set_params(8'h08, 4, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (int'(pwm_duty_cycle) != exp_seq[i] || busy !== 1'b1 || done !== (exp_seq[i] == 8)) begin
        n_fail++;
        $display("FAIL breathe cyc=%0d: duty=%02h busy=%b done=%b, required %02h 1 %b",
                 i, pwm_duty_cycle, busy, done, exp_seq[i], exp_seq[i] == 8);
      end
    end
    breathe = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_checks++;
      if (i < 4) begin
        if (int'(pwm_duty_cycle) != exp_tail[i] || busy !== (i < 3) || done !== (i == 3)) begin
          n_fail++;
          $display("FAIL breathe_stop cyc=%0d: duty=%02h busy=%b done=%b, required %02h %b %b",
                   i, pwm_duty_cycle, busy, done, exp_tail[i], i < 3, i == 3);
        end
      end else if (pwm_duty_cycle !== 8'h08 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL breathe_hold cyc=%0d: duty=%02h busy=%b done=%b, required 08 0 0",
                 i, pwm_duty_cycle, busy, done);
      end
    end
    $display("txn breathe: duty=%02h", pwm_duty_cycle);
  endtask
`else
  task automatic test_breathe();
    do_reset();
    breathe = 1'b1;
    set_params(8'h08, 4, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_checks++;
      if (pwm_duty_cycle !== 8'(m_duty) || busy !== m_ramp || done !== m_done) begin
        n_fail++;
        $display("FAIL breathe_ignored cyc=%0d: duty=%02h busy=%b done=%b, required %02h %b %b",
                 i, pwm_duty_cycle, busy, done, m_duty[7:0], m_ramp, m_done);
      end
    end
    breathe = 1'b0;
    $display("txn breathe_ignored: duty=%02h", pwm_duty_cycle);
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; breathe = 1'b0;
    target_duty = 8'h00; step_size = 4'd0; prescale = 8'h00;
    model_reset();
    test_reset();
    test_ramp_fast();
    test_ramp_slow();
    test_full_scale();
    test_abort();
    test_mid_reset();
    test_back_to_back();
    test_random();
    test_breathe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_fade_controller.md
PWM_FADE_CONTROLLER -- requirements
Module: pwm_fade_controller

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL have port start  input  1  one-cycle request to fade toward target_duty.
REQ-004 SHALL have port abort  input  1  one-cycle request to freeze the fade at the current duty.
REQ-005 SHALL have port target_duty  input  8  fade endpoint, sampled only when start is accepted.
REQ-006 SHALL have port step_size  input  4  duty increment per step; value 0 treated as 1; sampled with start.
REQ-007 SHALL have port prescale  input  8  step period = prescale+1 clk cycles; sampled with start.
REQ-008 SHALL have port breathe  input  1  continuous fade mode request (see Configuration).
REQ-009 SHALL have port pwm_duty_cycle  output  8  current duty, registered, drives the PWM peripheral duty input.
REQ-010 SHALL have port busy  output  1  high in RAMP_UP or RAMP_DOWN.
REQ-011 SHALL have port done  output  1  one-cycle pulse when duty reaches the latched target.

Function
REQ-012 SHALL implement states IDLE, RAMP_UP, RAMP_DOWN, HOLD.
REQ-013 Accepted start SHALL latch target, step and prescale, clear the prescale counter, and go to RAMP_UP if target > duty, RAMP_DOWN if target < duty, HOLD with done pulsed on the next edge if equal.
REQ-014 In RAMP states the prescale counter SHALL increment each cycle; when it equals the latched prescale it SHALL clear and duty SHALL step by one step_size.
REQ-015 With prescale P, the first duty change SHALL appear at edge N+1+P after start is sampled at edge N; subsequent changes every P+1 cycles.
REQ-016 Arithmetic SHALL be 9-bit internally; each step SHALL saturate at the latched target (no overshoot, no 8-bit wrap below 0x00 or above 0xFF).
REQ-017 When duty equals target the state SHALL go to HOLD, done SHALL pulse for exactly one cycle coincident with that final duty value, busy SHALL drop the same cycle.
REQ-018 Start during a RAMP state SHALL retarget: relatch all parameters, recompute direction, prescale counter NOT cleared.
REQ-019 Abort SHALL move any state to HOLD with duty frozen and no done pulse; abort in IDLE/HOLD SHALL have no effect.
REQ-020 Start and abort in the same cycle: abort SHALL win, start SHALL be ignored.
REQ-021 HOLD SHALL keep duty constant until the next start; IDLE SHALL behave as HOLD with duty 0.

Reset
REQ-022 While rst_n is low at a clk edge: state IDLE, pwm_duty_cycle 0x00, busy 0, done 0, prescale counter 0, latched parameters 0.
REQ-023 Reset asserted mid-ramp SHALL take priority over start/abort and abandon the fade with no done pulse.

Configuration
REQ-024 Macro PWM_FADE_BREATHE_EN SHALL compile in breathe mode.
REQ-025 With PWM_FADE_BREATHE_EN defined and breathe high on reaching target: instead of HOLD, SHALL ramp down to 0x00 then up to target repeatedly using latched step/prescale; done SHALL pulse on each arrival at target; busy stays high; abort or breathe low stops at the next target arrival (abort immediately).
REQ-026 Without PWM_FADE_BREATHE_EN the breathe port SHALL exist but be ignored; behaviour as REQ-012..021.

Verification
REQ-027 rst_n low 2 cycles mid-ramp -> duty 0x00, busy 0, done 0, no done after release.
REQ-028 From 0x00, start target 0x10, step 4, prescale 0 -> duty 0x04,0x08,0x0C,0x10 on consecutive edges; done single pulse with 0x10; busy low thereafter.
REQ-029 From 0x00, target 0x0A, step 4, prescale 3 -> 0x04,0x08,0x0A at 4-cycle spacing; never 0x0C.
REQ-030 From 0xFF, target 0x00, step 15, prescale 0 -> 17 steps ending 0x00, no wrap, one done.
REQ-031 Abort at duty 0x08 mid-ramp -> HOLD, duty stays 0x08, no done; start+abort same cycle -> start ignored.
REQ-032 PWM_FADE_BREATHE_EN, breathe 1, target 0x08, step 4, prescale 0 -> 0x04,0x08,0x04,0x00,0x04,0x08...; done at each 0x08.
